rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  N-channel, W-bit registered arbitrating multiplexer with valid/ready handshake.
//  Generalises the fixed 2:1/4:1 select muxes: the select is produced internally
//  (round-robin or fixed priority) rather than supplied by the caller.
//  The result is held in one output register stage.
//  Sits between multiple request producers (e.g. I/D memory ports, MMIO masters)
//  and a single shared consumer in the CPU datapath.
// PARAMETERS
//  W          32  data width per channel
//  N          4   number of input channels (>=2, need not be a power of 2)
//  FIXED_PRI  0   0 = round-robin arbitration; 1 = fixed priority, lowest index wins
//  (derived) SW = $clog2(N), width of the channel index
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_data    in   N*W    channel i occupies bits [i*W +: W]
//  in_valid   in   N      channel i presents a request
//  in_ready   out  N      channel i request accepted this cycle (one-hot or zero)
//  out_data   out  W      registered selected data
//  out_src    out  SW     index of the channel that supplied out_data
//  out_valid  out  1      out_data/out_src hold a pending result
//  out_ready  in   1      consumer accepts the result this cycle
// BEHAVIOUR
//  Reset (async, rst=1):
//   - out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
//   - in_ready is forced to 0 while rst=1.
//   - A pending output is discarded when rst is asserted mid-operation.
//  Load enable: load = ~out_valid | out_ready. This is combinational, so ready
//   propagates through the register in the same cycle.
//  Grant g, combinational:
//   - Round-robin: the first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod N.
//   - Fixed priority: scan from 0 upward.
//  in_ready[i] = ~rst & load & (|in_valid) & (i==g). At most one bit is set.
//  Transfer occurs on a rising edge when load & (|in_valid):
//   - out_data <= in_data[g]; out_src <= g; out_valid <= 1.
//   - Round-robin only: ptr <= (g==N-1) ? 0 : g+1 (wrap for any N).
//  Load with no valid input: out_valid <= 0; out_data/out_src hold their old values.
//  Stall (out_valid & ~out_ready):
//   - out_data, out_src and ptr are stable.
//   - All in_ready=0.
//   - Inputs must hold their data while valid and not ready.
//  Timing:
//   - Latency: 1 cycle from in_valid&in_ready to out_valid.
//   - Throughput: 1 transfer per cycle while out_ready=1.
//  Fairness:
//   - Round-robin: with all channels valid continuously, each is granted exactly
//     once per N transfers.
//   - Fixed priority: starvation is permitted.
//  Simultaneous events: a drain (out_ready) and a new grant in the same cycle
//   produce back-to-back output with no bubble.
//  ptr advances only on an actual transfer, never on idle or stall cycles.
// TESTING
//  1 Reset: rst=1 with in_valid=4'hF, out_ready=1 -> in_ready=0, out_valid=0,
//    out_data=0. Release rst -> the first grant goes to ch0.
//  2 RR sweep: all valid, in_data[i]=32'h10+i, out_ready=1 ->
//    out_src=0,1,2,3,0 on successive cycles; out_data=32'h10..13,10.
//  3 Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 ->
//    out_data/out_src unchanged, in_ready=4'b0. Raise out_ready -> next grant
//    follows the pre-stall ptr.
//  4 Sparse: only ch2 valid (32'hA5) -> next cycle out_data=32'hA5, out_src=2.
//    Then ch1 and ch3 valid -> ch3 is granted (ptr=3), then ch1.
//  5 Fixed priority (FIXED_PRI=1): all valid for 4 transfers -> out_src=0 each
//    time. Drop ch0 -> ch1 is granted.
//  6 Wrap/odd N (N=3): ch2 and ch0 valid, ptr=2 -> ch2 then ch0. No X on
//    out_src. Assert rst mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: bundle of the arbitrating mux's request and result handshakes.
//   in_data   N*W  channel i data at [i*W +: W]
//   in_valid  N    per-channel request
//   in_ready  N    per-channel accept (one-hot or zero)
//   out_data  W    registered selected data
//   out_src   SW   channel index that supplied out_data
//   out_valid 1    result pending
//   out_ready 1    consumer accepts result
//   master: producer/consumer side; slave: the arbiter itself.
interface rr_arb_mux_if #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel W-bit registered arbitrating mux, round-robin or fixed priority.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  rr_arb_mux_if.slave: in_data/in_valid/in_ready requests, out_* registered result
module rr_arb_mux #(
    parameter int W         = 32,
    parameter int N         = 4,
    parameter bit FIXED_PRI = 0,
    localparam int SW       = $clog2(N)
) (
    input logic        clk,
    input logic        rst,
    rr_arb_mux_if.slave bus
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] g;
    logic [SW-1:0] ptr_next;
    logic          any;
    logic          load;
    logic          found;
    int            idx;

    assign any  = |bus.in_valid;
    assign load = ~bus.out_valid | bus.out_ready;

    // Scan from the priority start index with wrap-around; the wrap is done
    // by subtraction so non-power-of-two N works.
    always_comb begin
        g     = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (FIXED_PRI ? 0 : int'(ptr)) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.in_valid[idx]) begin
                g     = SW'(idx);
                found = 1'b1;
            end
        end
    end

    assign ptr_next     = (g == SW'(N - 1)) ? '0 : g + 1'b1;
    assign bus.in_ready = (~rst & load & any) ? N'(1) << g : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            ptr           <= '0;
        end else if (load) begin
            bus.out_valid <= any;
            if (any) begin
                bus.out_data <= bus.in_data[g*W +: W];
                bus.out_src  <= g;
                if (!FIXED_PRI) ptr <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: three arbiters (RR N=4, fixed N=4, RR N=3) against a scan-based model.
module tb_rr_arb_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dat [3][4];
    logic [3:0]  vld [3];
    logic [2:0]  orr;
    logic [3:0]  rdy [3];
    logic [31:0] od  [3];
    logic [1:0]  os  [3];
    logic [2:0]  ov;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    rr_arb_mux_if #(.W(32), .N(4)) ia ();
    rr_arb_mux_if #(.W(32), .N(4)) ib ();
    rr_arb_mux_if #(.W(32), .N(3)) ic ();

    rr_arb_mux #(.W(32), .N(4), .FIXED_PRI(0)) ua (.clk(clk), .rst(rst), .bus(ia));
    rr_arb_mux #(.W(32), .N(4), .FIXED_PRI(1)) ub (.clk(clk), .rst(rst), .bus(ib));
    rr_arb_mux #(.W(32), .N(3), .FIXED_PRI(0)) uc (.clk(clk), .rst(rst), .bus(ic));

    assign ia.in_data   = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    assign ib.in_data   = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
    assign ic.in_data   = {dat[2][2], dat[2][1], dat[2][0]};
    assign ia.in_valid  = vld[0];
    assign ib.in_valid  = vld[1];
    assign ic.in_valid  = vld[2][2:0];
    assign ia.out_ready = orr[0];
    assign ib.out_ready = orr[1];
    assign ic.out_ready = orr[2];
    assign rdy[0] = ia.in_ready;
    assign rdy[1] = ib.in_ready;
    assign rdy[2] = {1'b0, ic.in_ready};
    assign od[0]  = ia.out_data;
    assign od[1]  = ib.out_data;
    assign od[2]  = ic.out_data;
    assign os[0]  = ia.out_src;
    assign os[1]  = ib.out_src;
    assign os[2]  = ic.out_src;
    assign ov     = {ic.out_valid, ib.out_valid, ia.out_valid};

    function automatic int nof(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic bit fx(int k);
        return k == 1;
    endfunction

    // First valid channel scanning start, start+1, ... modulo n; -1 if none.
    function automatic int gnt(logic [3:0] v, int start, int n);
        for (int j = 0; j < n; j++)
            if (v[(start + j) % n]) return (start + j) % n;
        return -1;
    endfunction

    int          ptr [3];
    logic        ev  [3];
    logic [31:0] ed  [3];
    int          es  [3];
    logic [3:0]  acc [3];

    function automatic int gk(int k);
        return gnt(vld[k], fx(k) ? 0 : ptr[k], nof(k));
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                ptr[k] <= 0;
                ev[k]  <= 1'b0;
                ed[k]  <= '0;
                es[k]  <= 0;
                acc[k] <= '0;
            end else if ((!ev[k] || orr[k]) && gk(k) >= 0) begin
                ev[k]  <= 1'b1;
                ed[k]  <= dat[k][gk(k)];
                es[k]  <= gk(k);
                acc[k] <= 4'(1 << gk(k));
                if (!fx(k)) ptr[k] <= (gk(k) + 1) % nof(k);
            end else begin
                if (!ev[k] || orr[k]) ev[k] <= 1'b0;
                acc[k] <= '0;
            end
        end
    end

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t act=%h exp=%h", nm, k, $time, act, exp);
        end
    endtask

    int          cg;
    logic [3:0]  cer;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                cg  = gk(k);
                cer = ((!ev[k] || orr[k]) && cg >= 0) ? 4'(1 << cg) : 4'b0;
                chk("in_ready", k, 32'(rdy[k]), 32'(cer));
                chk("out_valid", k, 32'(ov[k]), 32'(ev[k]));
                chk("out_data", k, od[k], ed[k]);
                chk("out_src", k, 32'(os[k]), es[k]);
            end
        end
    end

    int dens;

    initial begin
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) dat[k][i] = 32'h10 * (k + 1) + i;
        vld[0] = 4'hF;
        vld[1] = 4'hF;
        vld[2] = 4'h0;
        orr    = 3'b111;
        #2;
        chk("rst_in_ready", 0, 32'(rdy[0]), 32'h0);
        chk("rst_out_valid", 0, 32'(ov[0]), 32'h0);
        chk("rst_out_data", 0, od[0], 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        vld[2] = 4'b0010;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) vld[2] = 4'b0101;
            if (j == 1) vld[2] = 4'b0001;
            if (j == 2) vld[2] = 4'b0000;
            if (j == 4) orr[0] = 1'b0;
            #1;
            chk("sweep_src", 0, 32'(os[0]), j % 4);
            chk("sweep_data", 0, od[0], 32'h10 + j % 4);
            chk("fixed_src", 1, 32'(os[1]), 0);
            if (j == 0) chk("wrap_src", 2, 32'(os[2]), 1);
            if (j == 1) chk("wrap_src", 2, 32'(os[2]), 2);
            if (j == 2) chk("wrap_src", 2, 32'(os[2]), 0);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            #1;
            chk("stall_src", 0, 32'(os[0]), 0);
            chk("stall_data", 0, od[0], 32'h10);
            chk("stall_ready", 0, 32'(rdy[0]), 0);
        end
        #1 orr[0] = 1'b1;
        @(negedge clk);
        vld[0]    = 4'b0100;
        dat[0][2] = 32'hA5;
        vld[1]    = 4'b1110;
        #1;
        chk("post_stall_src", 0, 32'(os[0]), 1);
        chk("fixed_src", 1, 32'(os[1]), 0);
        @(negedge clk);
        vld[0] = 4'b1010;
        #1;
        chk("sparse_src", 0, 32'(os[0]), 2);
        chk("sparse_data", 0, od[0], 32'hA5);
        chk("fixed_drop0", 1, 32'(os[1]), 1);
        @(negedge clk);
        vld[0] = 4'b0010;
        #1;
        chk("sparse_src", 0, 32'(os[0]), 3);
        chk("sparse_data", 0, od[0], 32'h13);
        @(negedge clk);
        vld[0] = 4'b0000;
        vld[2] = 4'b0001;
        orr[2] = 1'b0;
        #1;
        chk("sparse_src", 0, 32'(os[0]), 1);
        chk("sparse_data", 0, od[0], 32'h11);
        @(negedge clk);
        vld[2] = 4'b0000;
        #1;
        chk("c_valid", 2, 32'(ov[2]), 1);
        @(negedge clk);
        #1;
        chk("c_stall_valid", 2, 32'(ov[2]), 1);
        chk("c_stall_data", 2, od[2], 32'h30);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 2, 32'(ov[2]), 0);
        chk("midrst_ready", 1, 32'(rdy[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        dens = 50;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) dens = $urandom_range(10, 95);
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < nof(k); i++) begin
                    if (!vld[k][i] || acc[k][i]) begin
                        vld[k][i] = ($urandom % 100) < dens;
                        dat[k][i] = $urandom;
                    end
                end
                orr[k] = ($urandom % 100) < 70;
            end
        end
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
